// File: rtl/arb_mux.sv
// arb_mux: selects one of CH valid/ready input channels into a single
// registered output stage. The channel comes either from an external
// select or from a round-robin arbiter. Full throughput: the output
// word can be replaced on the same edge it drains.
module arb_mux #(
    parameter int N    = 32,
    parameter int CH   = 4,
    parameter int MODE = 0,
    localparam int SW  = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*N-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    input  logic [SW-1:0]     sel,
    output logic [N-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     grant
);

    // Channel count widened by one bit so sel can be range-checked.
    localparam logic [SW:0]   CH_W    = (SW+1)'(CH);
    localparam logic [SW-1:0] LAST_CH = SW'(CH - 1);

    logic [N-1:0]  out_data_r;
    logic          out_valid_r;
    logic [SW-1:0] grant_r;
    logic [SW-1:0] ptr_r;

    logic          can_load_s;
    logic          found_s;
    logic [SW-1:0] chosen_s;
    logic [SW:0]   rr_idx_s;
    logic [CH-1:0] in_ready_s;
    logic          xfer_s;
    logic [SW-1:0] ptr_next_s;

    // Output stage can accept a word when empty or draining; never during reset.
    always_comb begin
        can_load_s = rst_n & (~out_valid_r | out_ready);
    end

    // Pick the channel: external select, or first valid channel from ptr onward.
    always_comb begin
        found_s  = 1'b0;
        chosen_s = {SW{1'b0}};
        rr_idx_s = {(SW+1){1'b0}};
        if (MODE == 1) begin
            for (int i = 0; i < CH; i++) begin
                rr_idx_s = {1'b0, ptr_r} + (SW+1)'(i);
                if (rr_idx_s >= CH_W) begin
                    rr_idx_s = rr_idx_s - CH_W;
                end else begin
                    rr_idx_s = rr_idx_s;
                end
                if (!found_s && in_valid[rr_idx_s[SW-1:0]]) begin
                    found_s  = 1'b1;
                    chosen_s = rr_idx_s[SW-1:0];
                end else begin
                    found_s  = found_s;
                    chosen_s = chosen_s;
                end
            end
        end else begin
            if ({1'b0, sel} < CH_W) begin
                found_s  = 1'b1;
                chosen_s = sel;
            end else begin
                found_s  = 1'b0;
                chosen_s = {SW{1'b0}};
            end
        end
    end

    // Only the chosen channel sees ready; an out-of-range or empty choice sees none.
    always_comb begin
        in_ready_s = {CH{1'b0}};
        if (found_s) begin
            in_ready_s[chosen_s] = can_load_s;
        end else begin
            in_ready_s = {CH{1'b0}};
        end
    end

    // Transfer qualifier and next round-robin pointer (one past the winner).
    always_comb begin
        xfer_s = found_s & in_valid[chosen_s] & in_ready_s[chosen_s];
        if (chosen_s == LAST_CH) begin
            ptr_next_s = {SW{1'b0}};
        end else begin
            ptr_next_s = chosen_s + SW'(1);
        end
    end

    // Output register stage: load on transfer, clear valid on idle drain, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {N{1'b0}};
            grant_r     <= {SW{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[int'(chosen_s)*N +: N];
            grant_r     <= chosen_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            grant_r     <= grant_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            grant_r     <= grant_r;
        end
    end

    // Round-robin pointer advances past each winner; pinned at zero with external select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SW{1'b0}};
        end else if ((MODE == 1) && xfer_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Drive ports from the registered state and the ready decode.
    always_comb begin
        in_ready  = in_ready_s;
        out_data  = out_data_r;
        out_valid = out_valid_r;
        grant     = grant_r;
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: three instances (select mode CH=4,
// round-robin CH=4, select mode CH=3) sharing clock and reset.
module tb_arb_mux;

    logic clk;
    logic rst_n;

    // Instance 0: MODE 0, CH 4
    logic [127:0] d0_in_data;
    logic [3:0]   d0_in_valid;
    logic [3:0]   d0_in_ready;
    logic [1:0]   d0_sel;
    logic [31:0]  d0_out_data;
    logic         d0_out_valid;
    logic         d0_out_ready;
    logic [1:0]   d0_grant;

    // Instance 1: MODE 1, CH 4
    logic [127:0] d1_in_data;
    logic [3:0]   d1_in_valid;
    logic [3:0]   d1_in_ready;
    logic [1:0]   d1_sel;
    logic [31:0]  d1_out_data;
    logic         d1_out_valid;
    logic         d1_out_ready;
    logic [1:0]   d1_grant;

    // Instance 2: MODE 0, CH 3
    logic [95:0]  d2_in_data;
    logic [2:0]   d2_in_valid;
    logic [2:0]   d2_in_ready;
    logic [1:0]   d2_sel;
    logic [31:0]  d2_out_data;
    logic         d2_out_valid;
    logic         d2_out_ready;
    logic [1:0]   d2_grant;

    int n_cmp;
    int n_err;

    arb_mux #(.N(32), .CH(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready), .grant(d0_grant)
    );

    arb_mux #(.N(32), .CH(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .grant(d1_grant)
    );

    arb_mux #(.N(32), .CH(3), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .grant(d2_grant)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        d0_in_data = 128'd0; d0_in_valid = 4'd0; d0_sel = 2'd0; d0_out_ready = 1'b0;
        d1_in_data = 128'd0; d1_in_valid = 4'd0; d1_sel = 2'd0; d1_out_ready = 1'b0;
        d2_in_data = 96'd0;  d2_in_valid = 3'd0; d2_sel = 2'd0; d2_out_ready = 1'b0;

        // Reset state, with a would-be transfer presented to dut0.
        d0_sel = 2'd2;
        d0_in_valid = 4'b0100;
        d0_in_data[2*32 +: 32] = 32'hDEADBEEF;
        d0_out_ready = 1'b1;
        #1;
        check_val("rst_valid", {63'd0, d0_out_valid}, 64'd0);
        check_val("rst_data", {32'd0, d0_out_data}, 64'd0);
        check_val("rst_grant", {62'd0, d0_grant}, 64'd0);
        check_val("rst_ready", {60'd0, d0_in_ready}, 64'd0);
        step();
        check_val("rst_edge_valid", {63'd0, d0_out_valid}, 64'd0);
        rst_n = 1'b1;

        // Select mode single transfer.
        #1;
        check_val("m0_ready", {60'd0, d0_in_ready}, 64'h4);
        step();
        check_val("m0_valid", {63'd0, d0_out_valid}, 64'd1);
        check_val("m0_data", {32'd0, d0_out_data}, 64'hDEADBEEF);
        check_val("m0_grant", {62'd0, d0_grant}, 64'd2);
        d0_in_valid = 4'b0000;
        step();
        check_val("m0_drain_valid", {63'd0, d0_out_valid}, 64'd0);
        check_val("m0_drain_data", {32'd0, d0_out_data}, 64'hDEADBEEF);

        // Backpressure: stored word stable, sel wiggling has no effect.
        d0_sel = 2'd0;
        d0_in_data[0 +: 32] = 32'h11;
        d0_in_data[32 +: 32] = 32'h55;
        d0_in_valid = 4'b0011;
        step();
        check_val("bp_load", {32'd0, d0_out_data}, 64'h11);
        d0_out_ready = 1'b0;
        d0_in_data[0 +: 32] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            d0_sel = (i == 1) ? 2'd1 : 2'd0;
            #1;
            check_val("bp_ready", {60'd0, d0_in_ready}, 64'd0);
            step();
            check_val("bp_hold_data", {32'd0, d0_out_data}, 64'h11);
            check_val("bp_hold_valid", {63'd0, d0_out_valid}, 64'd1);
            check_val("bp_hold_grant", {62'd0, d0_grant}, 64'd0);
        end
        d0_sel = 2'd0;
        d0_out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", {60'd0, d0_in_ready}, 64'h1);
        step();
        check_val("bp_nobubble_valid", {63'd0, d0_out_valid}, 64'd1);
        check_val("bp_nobubble_data", {32'd0, d0_out_data}, 64'h22);
        d0_in_valid = 4'b0000;

        // Round-robin with all channels valid.
        for (int k = 0; k < 4; k++) d1_in_data[k*32 +: 32] = 32'h100 + k;
        d1_in_valid = 4'b1111;
        d1_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_g = 2'(i % 4);
            #1;
            check_val("rr_ready", {60'd0, d1_in_ready}, 64'd1 << exp_g);
            step();
            check_val("rr_grant", {62'd0, d1_grant}, {62'd0, exp_g});
            check_val("rr_data", {32'd0, d1_out_data}, 64'h100 + exp_g);
        end

        // Wrap-around: grant 0, then skip 1 and 2 to reach 3, then back to 0.
        d1_in_valid = 4'b0001;
        step();
        check_val("wrap_g0", {62'd0, d1_grant}, 64'd0);
        check_val("wrap_ptr1", {62'd0, dut1.ptr_r}, 64'd1);
        d1_in_valid = 4'b1001;
        #1;
        check_val("wrap_ready", {60'd0, d1_in_ready}, 64'h8);
        step();
        check_val("wrap_g3", {62'd0, d1_grant}, 64'd3);
        check_val("wrap_d3", {32'd0, d1_out_data}, 64'h103);
        check_val("wrap_ptr0", {62'd0, dut1.ptr_r}, 64'd0);
        step();
        check_val("wrap_g0b", {62'd0, d1_grant}, 64'd0);

        // No valid inputs: no ready, output drains, grant holds.
        d1_in_valid = 4'b0000;
        #1;
        check_val("idle_ready", {60'd0, d1_in_ready}, 64'd0);
        step();
        check_val("idle_valid", {63'd0, d1_out_valid}, 64'd0);
        check_val("idle_grant", {62'd0, d1_grant}, 64'd0);

        // Fairness with two contenders from ptr=1: 1,0,1,0.
        d1_in_valid = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("fair_grant", {62'd0, d1_grant}, (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        d1_in_valid = 4'b0000;

        // CH=3: out-of-range sel blocks everything; legal sel works.
        d2_in_data[32 +: 32] = 32'h33;
        d2_in_valid = 3'b111;
        d2_sel = 2'd3;
        d2_out_ready = 1'b1;
        #1;
        check_val("oor_ready", {61'd0, d2_in_ready}, 64'd0);
        step();
        check_val("oor_valid", {63'd0, d2_out_valid}, 64'd0);
        d2_sel = 2'd1;
        step();
        check_val("ch3_grant", {62'd0, d2_grant}, 64'd1);
        check_val("ch3_data", {32'd0, d2_out_data}, 64'h33);
        d2_in_valid = 3'b000;

        // Asynchronous reset mid-stall discards the held word.
        d1_in_valid = 4'b0100;
        d1_out_ready = 1'b1;
        step();
        check_val("stall_g2", {62'd0, d1_grant}, 64'd2);
        d1_in_valid = 4'b0000;
        d1_out_ready = 1'b0;
        step();
        check_val("stall_valid", {63'd0, d1_out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", {63'd0, d1_out_valid}, 64'd0);
        check_val("arst_data", {32'd0, d1_out_data}, 64'd0);
        check_val("arst_grant", {62'd0, d1_grant}, 64'd0);
        check_val("arst_ptr", {62'd0, dut1.ptr_r}, 64'd0);
        d1_in_valid = 4'b1111;
        d1_out_ready = 1'b1;
        #1;
        check_val("arst_ready", {60'd0, d1_in_ready}, 64'd0);
        step();
        check_val("arst_edge_valid", {63'd0, d1_out_valid}, 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_ready", {60'd0, d1_in_ready}, 64'h1);
        step();
        check_val("post_rst_grant", {62'd0, d1_grant}, 64'd0);
        check_val("post_rst_data", {32'd0, d1_out_data}, 64'h100);
        check_val("post_rst_valid", {63'd0, d1_out_valid}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N, default 32, data width in bits of every channel and of the output.
REQ-002 Parameter CH, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 0, channel selection: 0 = external select (sel), 1 = round-robin arbitration.
REQ-004 Local width SW = $clog2(CH), the index width used by sel and grant.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  CH*N  channel k occupies bits [k*N +: N].
REQ-008 in_valid  input  CH  per-channel valid.
REQ-009 in_ready  output  CH  per-channel ready, combinational.
REQ-010 sel  input  SW  channel index in MODE 0; ignored in MODE 1.
REQ-011 out_data  output  N  registered selected data.
REQ-012 out_valid  output  1  registered; out_data holds a valid word.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 grant  output  SW  registered index of the channel that produced out_data.

Function
REQ-015 The block SHALL contain one output register stage (out_data, out_valid, grant) and, in MODE 1, a round-robin pointer ptr of SW bits.
REQ-016 Internal signal can_load = !out_valid || out_ready.
REQ-017 The chosen channel c SHALL be: MODE 0: sel; MODE 1: first k with in_valid[k]=1, searching ptr, ptr+1, ... wrapping modulo CH.
REQ-018 in_ready[c] SHALL equal can_load; all other in_ready bits SHALL be 0.
REQ-019 In MODE 0 with sel >= CH, no channel SHALL be chosen: in_ready all 0, no transfer.
REQ-020 In MODE 1 with in_valid all 0, no channel SHALL be chosen; in_ready all 0.
REQ-021 A transfer SHALL occur when in_valid[c] && in_ready[c]; on that edge out_data <= channel c data, grant <= c, out_valid <= 1.
REQ-022 Latency: input transfer at edge t -> out_valid=1 with that data after edge t; 1 cycle.
REQ-023 If out_ready=1 and no transfer occurs, out_valid SHALL clear to 0; out_data and grant SHALL hold.
REQ-024 While out_valid=1 and out_ready=0, out_data, grant and out_valid SHALL remain stable and in_ready SHALL be all 0.
REQ-025 Simultaneous output drain and input transfer in one cycle SHALL replace the word with no bubble (full throughput, one word per cycle).
REQ-026 In MODE 1, after a transfer from channel c, ptr SHALL become (c+1) mod CH; with no transfer ptr SHALL hold.
REQ-027 In MODE 0, ptr SHALL stay 0 and unused.
REQ-028 A channel SHALL never be granted twice in succession while another channel is continuously valid (MODE 1 fairness); worst-case wait CH-1 transfers.
REQ-029 Changing sel while out_valid=1 and out_ready=0 SHALL NOT alter the stored word.

Reset
REQ-030 On rst_n=0, asynchronously: out_valid=0, out_data=0, grant=0, ptr=0; in_ready all 0 while rst_n=0.
REQ-031 Reset asserted mid-stall SHALL discard the held word; after release the first transfer behaves as from idle.
REQ-032 Release of rst_n SHALL take effect at the next rising clk edge; no transfer on the release edge unless rst_n is high at that edge.

Verification
REQ-033 MODE 0, N=32, CH=4: sel=2, in_valid=4'b0100, ch2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, grant=2; in_ready=4'b0100.
REQ-034 MODE 0 backpressure: load 0x11, hold out_ready=0 for 3 cycles, ch0 changes to 0x22 -> out_data stays 0x11, in_ready=0; out_ready=1 -> 0x22 loaded next edge, no bubble.
REQ-035 MODE 1, CH=4: all in_valid=1, out_ready=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3.
REQ-036 MODE 1: ptr=1 after grant 0, in_valid=4'b1001 -> grant 3, then ptr=0 -> grant 0; wrap-around verified.
REQ-037 MODE 0, CH=3: sel=3 with in_valid=3'b111 -> in_ready=3'b000, out_valid stays 0.
REQ-038 Assert rst_n=0 mid-cycle while out_valid=1, out_ready=0 -> out_valid, out_data, grant, ptr read 0 immediately, before the next clk edge.
